// File: rtl/ram_pkg.sv
// Shared definitions for the masked two-port RAM family.
// Contents:
//   RDW_OLD / RDW_NEW  read-during-write selector values
//   MASK_EXP_MAX       widest word mask_expand can serve
//   init_state_e       post-reset clear sequencer states
//   addr_bits()        address width for a given depth (minimum 1)
//   mask_expand()      widen a write mask so each mask bit covers gran data bits
package ram_pkg;

    localparam int RDW_OLD      = 0;
    localparam int RDW_NEW      = 1;
    localparam int MASK_EXP_MAX = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } init_state_e;

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Callers zero-extend their mask in and truncate the result to their word width.
    function automatic logic [MASK_EXP_MAX-1:0] mask_expand(input logic [MASK_EXP_MAX-1:0] mask,
                                                             input int gran);
        logic [MASK_EXP_MAX-1:0] bits;
        int g;
        g    = (gran < 1) ? 1 : gran;
        bits = '0;
        for (int i = 0; i < MASK_EXP_MAX; i++) begin
            bits[i] = mask[i / g];
        end
        return bits;
    endfunction

endpackage

// File: rtl/ram_tp_bytemask_pipe_if.sv
// Request/response bundle of the masked two-port RAM.
// Signals:
//   cen        chip enable, gates both ports
//   wen/wmask/waddr/wdata   write port
//   ren/raddr               read port
//   rdata/rvalid            read response (rvalid is a one-cycle pulse)
//   init_busy               clear sequence running, requests ignored
//   addr_err                one-cycle pulse after an out-of-range request
// Modports: master drives requests, slave (the RAM) drives responses.
interface ram_tp_bytemask_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int MASK_WIDTH = 4
);
    logic                  cen;
    logic                  wen;
    logic [MASK_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ren;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  init_busy;
    logic                  addr_err;

    modport master (
        output cen, wen, wmask, waddr, wdata, ren, raddr,
        input  rdata, rvalid, init_busy, addr_err
    );

    modport slave (
        input  cen, wen, wmask, waddr, wdata, ren, raddr,
        output rdata, rvalid, init_busy, addr_err
    );
endinterface

// File: rtl/ram_init_seq.sv
// Post-reset clear sequencer: walks addresses 0..DEPTH-1 writing zero, one per cycle.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high; restarts the walk at address 0
//   init_busy  high while the array is not yet ready for traffic
//   clr_addr   address being cleared this cycle
//   clr_we     write-enable for the clear write
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int INIT_CLEAR = 1,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  init_busy,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    init_state_e           state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    // Reset enters CLEAR directly so init_busy lasts exactly DEPTH cycles.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= (INIT_CLEAR != 0) ? CLEAR : READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    state_nxt = READY;
                end else begin
                    cnt_nxt = cnt + ADDR_WIDTH'(1);
                end
            end
            READY:   state_nxt = READY;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        init_busy = (state != READY);
        clr_we    = (state == CLEAR);
        clr_addr  = cnt;
    end

endmodule

// File: rtl/ram_tp_bytemask_pipe.sv
// Two-port (1W/1R) synchronous RAM with granular write mask, 1- or 2-cycle read
// pipeline, selectable read-during-write result, post-reset clear and range checking.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    ram_tp_bytemask_pipe_if.slave (requests in, rdata/rvalid/init_busy/addr_err out)
module ram_tp_bytemask_pipe
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int MASK_GRAN  = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    parameter int INIT_CLEAR = 1
) (
    input logic                   clock,
    input logic                   reset,
    ram_tp_bytemask_pipe_if.slave bus
);

    localparam int ADDR_WIDTH = addr_bits(DEPTH);
    localparam int MASK_WIDTH = DATA_WIDTH / MASK_GRAN;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    if (MASK_GRAN < 1 || (DATA_WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
        $error("DATA_WIDTH must be a multiple of MASK_GRAN");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
        $error("RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH > MASK_EXP_MAX) begin : g_bad_width
        $error("DATA_WIDTH exceeds MASK_EXP_MAX");
    end

    // NOTE: the array has no reset so it maps onto RAM macros; the init sequencer zeroes it.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  init_busy, clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  accept, waddr_ok, raddr_ok, wr_hit, rd_hit;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] bit_mask, wr_merged, rd_word;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q, addr_err_q;

    ram_init_seq #(
        .DEPTH      (DEPTH),
        .INIT_CLEAR (INIT_CLEAR),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clock     (clock),
        .reset     (reset),
        .init_busy (init_busy),
        .clr_addr  (clr_addr),
        .clr_we    (clr_we)
    );

    assign accept   = bus.cen && !init_busy && !reset;
    assign waddr_ok = {1'b0, bus.waddr} < DEPTH_LIM;
    assign raddr_ok = {1'b0, bus.raddr} < DEPTH_LIM;
    assign wr_hit   = accept && bus.wen && waddr_ok;
    assign rd_hit   = accept && bus.ren;

    // Out-of-range addresses are steered to word 0 so the array is never indexed past DEPTH.
    assign wr_idx = waddr_ok ? bus.waddr : '0;
    assign rd_idx = raddr_ok ? bus.raddr : '0;

    assign bit_mask  = DATA_WIDTH'(mask_expand(MASK_EXP_MAX'(bus.wmask), MASK_GRAN));
    assign wr_merged = (bus.wdata & bit_mask) | (mem[wr_idx] & ~bit_mask);

    // Same-address read/write either sees the stored word or the merged write word.
    always_comb begin
        rd_word = '0;
        if (raddr_ok) begin
            if (RDW_MODE == RDW_NEW && wr_hit && bus.waddr == bus.raddr) begin
                rd_word = wr_merged;
            end else begin
                rd_word = mem[rd_idx];
            end
        end
    end

    // Single write port shared by the clear sequencer and user writes; the two never
    // overlap because requests are refused while clearing.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_hit) begin
            mem[wr_idx] <= wr_merged;
        end
    end

    // Read data is captured at acceptance, so later writes cannot disturb in-flight reads.
    if (RD_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clock) begin
            if (reset) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rd_hit;
                if (rd_hit) rdata_q <= rd_word;
            end
        end
    end else begin : g_lat2
        logic                  s1_valid;
        logic [DATA_WIDTH-1:0] s1_data;

        always_ff @(posedge clock) begin
            if (rd_hit) s1_data <= rd_word;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                s1_valid <= 1'b0;
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                s1_valid <= rd_hit;
                rvalid_q <= s1_valid;
                if (s1_valid) rdata_q <= s1_data;
            end
        end
    end

    // One pulse even when both ports are out of range in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= accept && ((bus.wen && !waddr_ok) || (bus.ren && !raddr_ok));
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.init_busy = init_busy;
    assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_ram_tp_bytemask_pipe.sv
// Bench: two RAM instances driven in lockstep by the same stimulus.
//   dut 0: DEPTH=16, RD_LATENCY=1, RDW_MODE=0 (old data)
//   dut 1: DEPTH=12, RD_LATENCY=2, RDW_MODE=1 (merged data)
// A per-cycle reference model predicts every output of both instances.
module tb_ram_tp_bytemask_pipe;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int MW = 4;

    int dep_m [2] = '{16, 12};
    int lat_m [2] = '{1, 2};
    int rdw_m [2] = '{0, 1};

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cen   = 1'b0;
    logic          wen   = 1'b0;
    logic          ren   = 1'b0;
    logic [MW-1:0] wmask = '0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] wdata = '0;

    always #5 clock = ~clock;

    ram_tp_bytemask_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW)) bus_a ();
    ram_tp_bytemask_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW)) bus_b ();

    assign bus_a.cen = cen;   assign bus_b.cen = cen;
    assign bus_a.wen = wen;   assign bus_b.wen = wen;
    assign bus_a.wmask = wmask; assign bus_b.wmask = wmask;
    assign bus_a.waddr = waddr; assign bus_b.waddr = waddr;
    assign bus_a.wdata = wdata; assign bus_b.wdata = wdata;
    assign bus_a.ren = ren;   assign bus_b.ren = ren;
    assign bus_a.raddr = raddr; assign bus_b.raddr = raddr;

    logic [DW-1:0] rdata_o  [2];
    logic          rvalid_o [2];
    logic          busy_o   [2];
    logic          err_o    [2];

    assign rdata_o[0] = bus_a.rdata;     assign rdata_o[1] = bus_b.rdata;
    assign rvalid_o[0] = bus_a.rvalid;   assign rvalid_o[1] = bus_b.rvalid;
    assign busy_o[0] = bus_a.init_busy;  assign busy_o[1] = bus_b.init_busy;
    assign err_o[0] = bus_a.addr_err;    assign err_o[1] = bus_b.addr_err;

    ram_tp_bytemask_pipe #(
        .DATA_WIDTH(DW), .DEPTH(16), .MASK_GRAN(8),
        .RD_LATENCY(1), .RDW_MODE(0), .INIT_CLEAR(1)
    ) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    ram_tp_bytemask_pipe #(
        .DATA_WIDTH(DW), .DEPTH(12), .MASK_GRAN(8),
        .RD_LATENCY(2), .RDW_MODE(1), .INIT_CLEAR(1)
    ) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] mm       [2][16];
    int            busy_left[2];
    bit            slot_v   [2][4];   // read results indexed by the edge they become visible
    logic [DW-1:0] slot_d   [2][4];
    logic          e_rvalid [2];
    logic          e_busy   [2];
    logic          e_err    [2];
    logic [DW-1:0] e_rdata  [2];
    int            edge_n = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_edge(input int d);
        int            dep, s;
        bit            acc, wr_ok, rd_ok;
        logic [DW-1:0] m, merged, val;
        dep = dep_m[d];
        if (reset) begin
            busy_left[d] = dep;
            for (int a = 0; a < 16; a++) mm[d][a] = '0;
            for (int k = 0; k < 4; k++) slot_v[d][k] = 1'b0;
            e_rvalid[d] = 1'b0;
            e_rdata[d]  = '0;
            e_err[d]    = 1'b0;
            e_busy[d]   = 1'b1;
            return;
        end
        acc = cen && (busy_left[d] == 0);
        if (busy_left[d] > 0) busy_left[d]--;
        e_busy[d] = (busy_left[d] > 0);
        m = '0;
        for (int b = 0; b < MW; b++) if (wmask[b]) m |= (32'hFF << (8 * b));
        merged = (wdata & m) | (mm[d][waddr] & ~m);
        wr_ok  = acc && wen && (int'(waddr) < dep);
        rd_ok  = acc && ren;
        e_err[d] = acc && ((wen && int'(waddr) >= dep) || (ren && int'(raddr) >= dep));
        if (rd_ok) begin
            if (int'(raddr) >= dep) val = '0;
            else if (rdw_m[d] == 1 && wr_ok && waddr == raddr) val = merged;
            else val = mm[d][raddr];
            s = (edge_n + lat_m[d] - 1) % 4;
            slot_v[d][s] = 1'b1;
            slot_d[d][s] = val;
        end
        if (wr_ok) mm[d][waddr] = merged;
        s = edge_n % 4;
        e_rvalid[d] = slot_v[d][s];
        if (slot_v[d][s]) e_rdata[d] = slot_d[d][s];
        slot_v[d][s] = 1'b0;
    endtask

    // One clock: advance the model at the edge, compare all outputs 1 ns later.
    task automatic step();
        @(posedge clock);
        edge_n++;
        model_edge(0);
        model_edge(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d.init_busy", d), DW'(busy_o[d]), DW'(e_busy[d]));
            check($sformatf("dut%0d.rvalid", d), DW'(rvalid_o[d]), DW'(e_rvalid[d]));
            check($sformatf("dut%0d.rdata", d), rdata_o[d], e_rdata[d]);
            check($sformatf("dut%0d.addr_err", d), DW'(err_o[d]), DW'(e_err[d]));
        end
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] dat, input logic [MW-1:0] mk);
        cen = 1'b1; wen = 1'b1; waddr = AW'(a); wdata = dat; wmask = mk;
        step();
        wen = 1'b0;
    endtask

    task automatic do_read(input int a, output logic [DW-1:0] ra, output logic [DW-1:0] rb);
        bit            got [2];
        logic [DW-1:0] r   [2];
        got[0] = 1'b0; got[1] = 1'b0; r[0] = '0; r[1] = '0;
        cen = 1'b1; ren = 1'b1; raddr = AW'(a);
        step();
        ren = 1'b0;
        for (int i = 0; i < 4 && !(got[0] && got[1]); i++) begin
            for (int d = 0; d < 2; d++) begin
                if (!got[d] && rvalid_o[d]) begin
                    got[d] = 1'b1;
                    r[d]   = rdata_o[d];
                end
            end
            if (!(got[0] && got[1])) step();
        end
        check("read_response_seen", DW'(got[0] && got[1]), DW'(1));
        ra = r[0];
        rb = r[1];
    endtask

    typedef struct {
        int            addr;
        logic [DW-1:0] dat;
        logic [MW-1:0] mk;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int            na, nb, nv;
        logic [DW-1:0] ra, rb;

        vecs[0] = '{3,  32'hAABBCCDD, 4'hF, 32'hAABBCCDD, 32'hAABBCCDD};
        vecs[1] = '{3,  32'h11223344, 4'h5, 32'hAA22CC44, 32'hAA22CC44};
        vecs[2] = '{5,  32'hFFFFFFFF, 4'h0, 32'h00000000, 32'h00000000};
        vecs[3] = '{14, 32'h12345678, 4'hF, 32'h12345678, 32'h00000000};
        vecs[4] = '{3,  32'h55000000, 4'h8, 32'h5522CC44, 32'h5522CC44};
        vecs[5] = '{11, 32'h0000BEEF, 4'h3, 32'h0000BEEF, 32'h0000BEEF};

        // Reset, then init_busy length and all-zero contents.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        na = 0; nb = 0;
        for (int i = 0; i < 24; i++) begin
            na += int'(busy_o[0]);
            nb += int'(busy_o[1]);
            step();
        end
        check("init_busy_cycles_a", DW'(na), DW'(16));
        check("init_busy_cycles_b", DW'(nb), DW'(12));
        for (int a = 0; a < 16; a++) begin
            do_read(a, ra, rb);
            check($sformatf("init_zero_a[%0d]", a), ra, '0);
            check($sformatf("init_zero_b[%0d]", a), rb, '0);
        end

        // Table: masked write followed by read-back.
        for (int v = 0; v < 6; v++) begin
            do_write(vecs[v].addr, vecs[v].dat, vecs[v].mk);
            do_read(vecs[v].addr, ra, rb);
            check($sformatf("vec%0d_a", v), ra, vecs[v].exp_a);
            check($sformatf("vec%0d_b", v), rb, vecs[v].exp_b);
        end

        // Read-during-write on address 7 (old word 9, new word 5).
        do_write(7, 32'h9, 4'hF);
        cen = 1'b1; wen = 1'b1; waddr = 4'd7; wdata = 32'h5; wmask = 4'hF;
        ren = 1'b1; raddr = 4'd7;
        step();
        wen = 1'b0; ren = 1'b0;
        check("rdw_old_valid_a", DW'(rvalid_o[0]), DW'(1));
        check("rdw_old_data_a", rdata_o[0], 32'h9);
        step();
        check("rdw_new_valid_b", DW'(rvalid_o[1]), DW'(1));
        check("rdw_new_data_b", rdata_o[1], 32'h5);
        do_read(7, ra, rb);
        check("rdw_after_a", ra, 32'h5);
        check("rdw_after_b", rb, 32'h5);

        // Back-to-back reads of 0,1,2: latency 1 vs latency 2, no bubbles.
        do_write(0, 32'd100, 4'hF);
        do_write(1, 32'd101, 4'hF);
        do_write(2, 32'd102, 4'hF);
        cen = 1'b1;
        for (int i = 0; i < 6; i++) begin
            raddr = AW'(i);
            ren   = (i < 3);
            step();
            check($sformatf("b2b_valid_a[%0d]", i), DW'(rvalid_o[0]), DW'(i <= 2));
            if (i <= 2) check($sformatf("b2b_data_a[%0d]", i), rdata_o[0], DW'(100 + i));
            check($sformatf("b2b_valid_b[%0d]", i), DW'(rvalid_o[1]), DW'(i >= 1 && i <= 3));
            if (i >= 1 && i <= 3) check($sformatf("b2b_data_b[%0d]", i), rdata_o[1], DW'(99 + i));
        end
        ren = 1'b0;

        // Range: addr 13 is out of range only for the 12-word instance.
        do_write(13, 32'hDEADBEEF, 4'hF);
        check("range_wr_err_b", DW'(err_o[1]), DW'(1));
        check("range_wr_err_a", DW'(err_o[0]), DW'(0));
        cen = 1'b1; ren = 1'b1; raddr = 4'd13;
        step();
        ren = 1'b0;
        check("range_rd_err_b", DW'(err_o[1]), DW'(1));
        check("range_rd_data_a", rdata_o[0], 32'hDEADBEEF);
        step();
        check("range_rd_valid_b", DW'(rvalid_o[1]), DW'(1));
        check("range_rd_data_b", rdata_o[1], 32'h0);
        check("range_err_cleared_b", DW'(err_o[1]), DW'(0));
        wen = 1'b1; waddr = 4'd14; wdata = 32'hCAFEF00D; wmask = 4'hF;
        ren = 1'b1; raddr = 4'd15;
        step();
        wen = 1'b0; ren = 1'b0;
        check("range_both_err_b", DW'(err_o[1]), DW'(1));
        step();
        check("range_both_single_pulse_b", DW'(err_o[1]), DW'(0));
        for (int a = 0; a < 12; a++) begin
            do_read(a, ra, rb);
            check($sformatf("range_intact_b[%0d]", a), rb, mm[1][a]);
        end

        // Reset at init cycle 5 restarts the clear sequence.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        na = 0; nb = 0;
        for (int i = 0; i < 24; i++) begin
            na += int'(busy_o[0]);
            nb += int'(busy_o[1]);
            step();
        end
        check("restart_busy_cycles_a", DW'(na), DW'(16));
        check("restart_busy_cycles_b", DW'(nb), DW'(12));

        // Reset with a latency-2 read in flight: no rvalid afterwards.
        cen = 1'b1; ren = 1'b1; raddr = 4'd2;
        step();
        ren = 1'b0;
        reset = 1'b1;
        step();
        check("inflight_dropped_b", DW'(rvalid_o[1]), DW'(0));
        check("inflight_rdata_b", rdata_o[1], '0);
        reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            nv += int'(rvalid_o[1]);
            step();
        end
        check("inflight_no_late_rvalid_b", DW'(nv), DW'(0));

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            cen   = ($urandom_range(0, 9) != 0);
            wen   = 1'($urandom_range(0, 1));
            ren   = 1'($urandom_range(0, 1));
            waddr = AW'($urandom_range(0, 15));
            raddr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 15));
            wdata = $urandom;
            wmask = MW'($urandom_range(0, 15));
            step();
        end
        reset = 1'b0; cen = 1'b0; wen = 1'b0; ren = 1'b0;
        step();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
